ibex_rf_ecc_scrubber: RTL and testbench

// - Background reader/corrector for the 39/32 ECC flop register file. Walks architectural

---
 rtl/ibex_ecc_pkg.sv | 38 +++
 rtl/ibex_rf_ecc_scrubber_if.sv | 25 ++
 rtl/ibex_secded_39_32_check.sv | 45 ++++
 rtl/ibex_rf_ecc_scrubber.sv | 162 ++++++++++++++++
 tb/tb_ibex_rf_ecc_scrubber.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_ecc_pkg.sv
// Shared definitions for the 39/32 Hsiao SEC-DED register-file code and its scrubber.
package ibex_ecc_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned ChkW  = 7;
    localparam int unsigned CodeW = DataW + ChkW;
    localparam int unsigned AddrW = 5;

    // Row k selects the data bits that feed check bit k.
    localparam logic [ChkW-1:0][DataW-1:0] H_MASK = {
        32'h5403FF10, 32'h8B503E88, 32'hA2BBC244, 32'h7D9C4422,
        32'hC06C89E1, 32'h13E5101F, 32'h2C0221FF
    };

    typedef logic [DataW-1:0][ChkW-1:0] col_syn_t;

    function automatic col_syn_t build_col_syn();
        col_syn_t tbl;
        tbl = '0;
        for (int j = 0; j < DataW; j++) begin
            for (int k = 0; k < ChkW; k++) begin
                tbl[j][k] = H_MASK[k][j];
            end
        end
        return tbl;
    endfunction

    // Syndrome produced by a single flip of data bit j.
    localparam col_syn_t COL_SYN = build_col_syn();

    typedef enum logic [1:0] {
        ScrubIdle,
        ScrubRead,
        ScrubCheck,
        ScrubWrite
    } scrub_state_e;

endpackage

// File: rtl/ibex_rf_ecc_scrubber_if.sv
// Register-file side of the scrubber: spare read port, shared write-back port, core write snoop.
interface ibex_rf_ecc_scrubber_if;
    import ibex_ecc_pkg::*;

    logic             rf_req_o;
    logic             rf_gnt_i;
    logic [AddrW-1:0] rf_addr_o;
    logic [CodeW-1:0] rf_rdata_i;
    logic             wb_req_o;
    logic             wb_gnt_i;
    logic [CodeW-1:0] wb_wdata_o;
    logic             core_we_i;
    logic [AddrW-1:0] core_waddr_i;

    modport master (
        output rf_req_o, rf_addr_o, wb_req_o, wb_wdata_o,
        input  rf_gnt_i, rf_rdata_i, wb_gnt_i, core_we_i, core_waddr_i
    );

    modport slave (
        input  rf_req_o, rf_addr_o, wb_req_o, wb_wdata_o,
        output rf_gnt_i, rf_rdata_i, wb_gnt_i, core_we_i, core_waddr_i
    );

endinterface

// File: rtl/ibex_secded_39_32_check.sv
// Combinational Hsiao 39/32 checker: syndrome, corrected codeword and SEC/DED flags.
module ibex_secded_39_32_check
    import ibex_ecc_pkg::*;
(
    input  logic [CodeW-1:0] i_code,
    output logic [ChkW-1:0]  o_syndrome,
    output logic [CodeW-1:0] o_corrected,
    output logic             o_sec,
    output logic             o_ded
);

    logic [DataW-1:0] w_data;
    logic [ChkW-1:0]  w_chk;
    logic [ChkW-1:0]  w_syn;
    logic [DataW-1:0] w_dataFlip;
    logic [ChkW-1:0]  w_chkFlip;
    logic             w_oddWeight;

    assign w_data = i_code[DataW-1:0];
    assign w_chk  = i_code[CodeW-1:DataW];

    always_comb begin
        w_syn = '0;
        for (int k = 0; k < ChkW; k++) begin
            w_syn[k] = (^(w_data & H_MASK[k])) ^ w_chk[k];
        end
    end

    assign w_oddWeight = ^w_syn;

    // Every data column has odd weight, so an even syndrome can never be a single data flip.
    always_comb begin
        w_dataFlip = '0;
        for (int j = 0; j < DataW; j++) begin
            w_dataFlip[j] = w_oddWeight && (w_syn == COL_SYN[j]);
        end
    end

    assign w_chkFlip   = $onehot(w_syn) ? w_syn : '0;
    assign o_syndrome  = w_syn;
    assign o_corrected = {w_chk ^ w_chkFlip, w_data ^ w_dataFlip};
    assign o_sec       = (|w_dataFlip) || (|w_chkFlip);
    assign o_ded       = (w_syn != '0) && !o_sec;

endmodule

// File: rtl/ibex_rf_ecc_scrubber.sv
// Background scrubber: walks the ECC register file, reports SEC/DED events and writes back
// corrected codewords, yielding to core writes that hit the word being scrubbed.
module ibex_rf_ecc_scrubber
    import ibex_ecc_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned IntervalW = 16,
    parameter int unsigned CntW      = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [IntervalW-1:0]   interval_i,
    ibex_rf_ecc_scrubber_if.master rf,
    output logic                   sec_o,
    output logic                   ded_o,
    output logic [AddrW-1:0]       err_addr_o,
    output logic [CntW-1:0]        sec_cnt_o,
    output logic [CntW-1:0]        ded_cnt_o,
    output logic                   pass_done_o
);

    localparam logic [AddrW-1:0] FirstAddr = 5'd1;
    localparam logic [AddrW-1:0] LastAddr  = RV32E ? 5'd15 : 5'd31;

    scrub_state_e        r_state;
    logic [AddrW-1:0]    r_addr;
    logic [IntervalW-1:0] r_interval;
    logic                r_coll;
    logic [CodeW-1:0]    r_wdata;
    logic [AddrW-1:0]    r_errAddr;
    logic [CntW-1:0]     r_secCnt;
    logic [CntW-1:0]     r_dedCnt;

    scrub_state_e        w_stateNext;
    logic [IntervalW-1:0] w_intervalNext;
    logic                w_collNext;
    logic                w_advance;
    logic                w_rfReq;
    logic                w_wbReq;
    logic                w_secEvt;
    logic                w_dedEvt;
    logic                w_collide;
    logic                w_lastAddr;
    logic [ChkW-1:0]     w_syndrome;
    logic [CodeW-1:0]    w_corrected;
    logic                w_chkSec;
    logic                w_chkDed;

    ibex_secded_39_32_check u_check (
        .i_code      (rf.rf_rdata_i),
        .o_syndrome  (w_syndrome),
        .o_corrected (w_corrected),
        .o_sec       (w_chkSec),
        .o_ded       (w_chkDed)
    );

    assign w_collide  = rf.core_we_i && (rf.core_waddr_i == r_addr);
    assign w_lastAddr = (r_addr == LastAddr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ScrubIdle;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A core write to the scrubbed word makes the read value stale: abandon the word silently.
    always_comb begin
        w_stateNext    = r_state;
        w_intervalNext = r_interval;
        w_collNext     = r_coll;
        w_advance      = 1'b0;
        w_rfReq        = 1'b0;
        w_wbReq        = 1'b0;
        w_secEvt       = 1'b0;
        w_dedEvt       = 1'b0;
        unique case (r_state)
            ScrubIdle: begin
                if (!en_i) begin
                    w_intervalNext = '0;
                end else if (r_interval >= interval_i) begin
                    w_intervalNext = '0;
                    w_stateNext    = ScrubRead;
                end else begin
                    w_intervalNext = r_interval + 1'b1;
                end
            end
            ScrubRead: begin
                w_rfReq = 1'b1;
                if (rf.rf_gnt_i) begin
                    w_stateNext = ScrubCheck;
                    w_collNext  = w_collide;
                end
            end
            ScrubCheck: begin
                w_collNext = 1'b0;
                if (r_coll || w_collide || (w_syndrome == '0)) begin
                    w_advance   = 1'b1;
                    w_stateNext = ScrubIdle;
                end else if (w_chkSec) begin
                    w_secEvt    = 1'b1;
                    w_stateNext = ScrubWrite;
                end else begin
                    w_dedEvt    = w_chkDed;
                    w_advance   = 1'b1;
                    w_stateNext = ScrubIdle;
                end
            end
            ScrubWrite: begin
                w_wbReq = !w_collide;
                if (rf.wb_gnt_i || w_collide) begin
                    w_advance   = 1'b1;
                    w_stateNext = ScrubIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr     <= FirstAddr;
            r_interval <= '0;
            r_coll     <= 1'b0;
            r_wdata    <= '0;
            r_errAddr  <= '0;
            r_secCnt   <= '0;
            r_dedCnt   <= '0;
        end else begin
            r_interval <= w_intervalNext;
            r_coll     <= w_collNext;
            if (w_advance) begin
                r_addr <= w_lastAddr ? FirstAddr : r_addr + 5'd1;
            end
            if (w_secEvt) begin
                r_wdata <= w_corrected;
            end
            if (w_secEvt || w_dedEvt) begin
                r_errAddr <= r_addr;
            end
            if (w_secEvt && (r_secCnt != '1)) begin
                r_secCnt <= r_secCnt + 1'b1;
            end
            if (w_dedEvt && (r_dedCnt != '1)) begin
                r_dedCnt <= r_dedCnt + 1'b1;
            end
        end
    end

    assign rf.rf_req_o   = w_rfReq;
    assign rf.rf_addr_o  = (r_state != ScrubIdle) ? r_addr : '0;
    assign rf.wb_req_o   = w_wbReq;
    assign rf.wb_wdata_o = r_wdata;
    assign sec_o         = w_secEvt;
    assign ded_o         = w_dedEvt;
    assign err_addr_o    = r_errAddr;
    assign sec_cnt_o     = r_secCnt;
    assign ded_cnt_o     = r_dedCnt;
    assign pass_done_o   = w_advance && w_lastAddr;

endmodule

// File: tb/tb_ibex_rf_ecc_scrubber.sv
// Directed bench for the ECC scrubber with a behavioural register file and arbiter.
module tb_ibex_rf_ecc_scrubber;

    localparam logic [31:0] HMASK [7] = '{32'h2C0221FF, 32'h13E5101F, 32'hC06C89E1,
                                          32'h7D9C4422, 32'hA2BBC244, 32'h8B503E88,
                                          32'h5403FF10};
    localparam logic [38:0] Garbage = 39'h55_5555_5555;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [15:0] interval_i;
    logic        sec_o;
    logic        ded_o;
    logic [4:0]  err_addr_o;
    logic [1:0]  sec_cnt_o;
    logic [1:0]  ded_cnt_o;
    logic        pass_done_o;

    ibex_rf_ecc_scrubber_if rfIf ();

    ibex_rf_ecc_scrubber #(
        .RV32E     (1'b0),
        .IntervalW (16),
        .CntW      (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .interval_i  (interval_i),
        .rf          (rfIf),
        .sec_o       (sec_o),
        .ded_o       (ded_o),
        .err_addr_o  (err_addr_o),
        .sec_cnt_o   (sec_cnt_o),
        .ded_cnt_o   (ded_cnt_o),
        .pass_done_o (pass_done_o)
    );

    always #5 clk = ~clk;

    logic [38:0] mem  [32];
    logic [38:0] orig [32];
    logic [38:0] coreVal;
    logic        autoGnt;
    logic        autoWbGnt;
    logic [4:0]  expAddr;
    logic [4:0]  lastReadAddr;
    logic [4:0]  lastEvtAddr;
    int total = 0;
    int bad = 0;
    int reads = 0;
    int secSeen = 0;
    int dedSeen = 0;
    int passSeen = 0;
    int wbSeen = 0;
    int idleCycles;
    int target;

    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [6:0] c;
        for (int k = 0; k < 7; k++) begin
            c[k] = ^(d & HMASK[k]);
        end
        return {c, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the register-file/arbiter model; returns shortly after the edge.
    task automatic applyStimulus();
        logic        rdGrant;
        logic        wrGrant;
        logic        coreWr;
        logic [4:0]  rdAddr;
        logic [4:0]  wrAddr;
        logic [4:0]  coreAddr;
        logic [38:0] wrData;
        #1;
        rfIf.rf_gnt_i = autoGnt && rfIf.rf_req_o;
        rfIf.wb_gnt_i = autoWbGnt && rfIf.wb_req_o;
        rdGrant  = rfIf.rf_gnt_i;
        rdAddr   = rfIf.rf_addr_o;
        wrGrant  = rfIf.wb_gnt_i;
        wrAddr   = rfIf.rf_addr_o;
        wrData   = rfIf.wb_wdata_o;
        coreWr   = rfIf.core_we_i;
        coreAddr = rfIf.core_waddr_i;
        if (rdGrant) begin
            checkOutput("readAddr", rdAddr, expAddr);
            reads++;
            lastReadAddr = rdAddr;
            expAddr = (expAddr == 5'd31) ? 5'd1 : expAddr + 5'd1;
        end
        @(posedge clk);
        #1;
        if (wrGrant) mem[wrAddr] = wrData;
        if (coreWr) mem[coreAddr] = coreVal;
        rfIf.rf_rdata_i   = rdGrant ? mem[rdAddr] : Garbage;
        rfIf.rf_gnt_i     = 1'b0;
        rfIf.wb_gnt_i     = 1'b0;
        rfIf.core_we_i    = 1'b0;
        rfIf.core_waddr_i = 5'd0;
        #1;
        if (sec_o) begin secSeen++; lastEvtAddr = rfIf.rf_addr_o; end
        if (ded_o) begin dedSeen++; lastEvtAddr = rfIf.rf_addr_o; end
        if (pass_done_o) passSeen++;
        if (rfIf.wb_req_o) wbSeen++;
    endtask

    // kind: 0 SEC pulses, 1 DED pulses, 2 pass_done pulses, 3 read grants
    task automatic waitEvent(input string tag, input int kind, input int tgt);
        int cnt;
        for (int i = 0; i < 400; i++) begin
            cnt = (kind == 0) ? secSeen : (kind == 1) ? dedSeen : (kind == 2) ? passSeen : reads;
            if (cnt >= tgt) break;
            applyStimulus();
        end
        cnt = (kind == 0) ? secSeen : (kind == 1) ? dedSeen : (kind == 2) ? passSeen : reads;
        checkOutput(tag, cnt, tgt);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            orig[i] = encode(32'h9E3779B9 * (i + 1));
            mem[i]  = orig[i];
        end
        rst_i = 1'b1;
        en_i = 1'b0;
        interval_i = 16'd0;
        autoGnt = 1'b1;
        autoWbGnt = 1'b1;
        expAddr = 5'd1;
        coreVal = '0;
        rfIf.rf_gnt_i = 1'b0;
        rfIf.wb_gnt_i = 1'b0;
        rfIf.rf_rdata_i = Garbage;
        rfIf.core_we_i = 1'b0;
        rfIf.core_waddr_i = 5'd0;

        $display("[TB] reset");
        repeat (3) applyStimulus();
        checkOutput("rstRfReq", rfIf.rf_req_o, 0);
        checkOutput("rstRfAddr", rfIf.rf_addr_o, 0);
        checkOutput("rstWbReq", rfIf.wb_req_o, 0);
        checkOutput("rstWdata", rfIf.wb_wdata_o, 0);
        checkOutput("rstSec", sec_o, 0);
        checkOutput("rstDed", ded_o, 0);
        checkOutput("rstErrAddr", err_addr_o, 0);
        checkOutput("rstSecCnt", sec_cnt_o, 0);
        checkOutput("rstDedCnt", ded_cnt_o, 0);
        checkOutput("rstPassDone", pass_done_o, 0);

        $display("[TB] idle interval then clean pass");
        rst_i = 1'b0;
        interval_i = 16'd3;
        en_i = 1'b1;
        idleCycles = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (rfIf.rf_req_o) break;
            idleCycles++;
        end
        checkOutput("intervalIdle", idleCycles, 3);
        checkOutput("firstReadAddr", rfIf.rf_addr_o, 1);
        interval_i = 16'd0;
        waitEvent("passDoneWait", 2, 1);
        en_i = 1'b0;
        checkOutput("cleanReads", reads, 31);
        checkOutput("cleanWbReqs", wbSeen, 0);
        checkOutput("cleanSecPulses", secSeen, 0);
        checkOutput("cleanDedPulses", dedSeen, 0);
        repeat (3) applyStimulus();
        checkOutput("parkedReq", rfIf.rf_req_o, 0);
        checkOutput("cleanSecCnt", sec_cnt_o, 0);
        checkOutput("cleanDedCnt", ded_cnt_o, 0);

        $display("[TB] SEC on data bit 13 of x5");
        mem[5] = orig[5] ^ (39'd1 << 13);
        en_i = 1'b1;
        waitEvent("secWait5", 0, secSeen + 1);
        checkOutput("secAddr5", lastEvtAddr, 5);
        applyStimulus();
        checkOutput("wbReq5", rfIf.wb_req_o, 1);
        checkOutput("wbData5", rfIf.wb_wdata_o, orig[5]);
        checkOutput("errAddr5", err_addr_o, 5);
        checkOutput("secCnt1", sec_cnt_o, 1);
        applyStimulus();
        checkOutput("memFixed5", mem[5], orig[5]);

        $display("[TB] SEC on check bit 3 of x7");
        mem[7] = orig[7] ^ (39'd1 << 35);
        waitEvent("secWait7", 0, secSeen + 1);
        checkOutput("secAddr7", lastEvtAddr, 7);
        applyStimulus();
        checkOutput("wbData7", rfIf.wb_wdata_o, orig[7]);
        checkOutput("secCnt2", sec_cnt_o, 2);
        applyStimulus();
        checkOutput("memFixed7", mem[7], orig[7]);

        $display("[TB] DED on data bits 0 and 1 of x9");
        mem[9] = orig[9] ^ 39'h3;
        waitEvent("dedWait9", 1, dedSeen + 1);
        checkOutput("dedAddr9", lastEvtAddr, 9);
        checkOutput("dedNoWbReq", rfIf.wb_req_o, 0);
        applyStimulus();
        checkOutput("dedCnt1", ded_cnt_o, 1);
        checkOutput("errAddr9", err_addr_o, 9);
        checkOutput("dedMemUntouched", mem[9], orig[9] ^ 39'h3);
        mem[9] = orig[9];

        $display("[TB] collision on x12 during write-back");
        mem[12] = orig[12] ^ (39'd1 << 4);
        autoWbGnt = 1'b0;
        waitEvent("secWait12", 0, secSeen + 1);
        checkOutput("secAddr12", lastEvtAddr, 12);
        applyStimulus();
        checkOutput("wbReq12", rfIf.wb_req_o, 1);
        applyStimulus();
        checkOutput("wbReqHeld12", rfIf.wb_req_o, 1);
        coreVal = encode(32'hDEADBEEF);
        rfIf.core_we_i = 1'b1;
        rfIf.core_waddr_i = 5'd12;
        applyStimulus();
        checkOutput("collWbDropped", rfIf.wb_req_o, 0);
        autoWbGnt = 1'b1;
        waitEvent("readWait13", 3, reads + 1);
        checkOutput("collNextAddr", lastReadAddr, 13);
        checkOutput("collCoreKept", mem[12], encode(32'hDEADBEEF));
        checkOutput("secCnt3", sec_cnt_o, 3);

        $display("[TB] reset while waiting for write-back on x20");
        mem[20] = orig[20] ^ (39'd1 << 20);
        autoWbGnt = 1'b0;
        waitEvent("secWait20", 0, secSeen + 1);
        checkOutput("secAddr20", lastEvtAddr, 20);
        applyStimulus();
        checkOutput("wbReq20", rfIf.wb_req_o, 1);
        rst_i = 1'b1;
        expAddr = 5'd1;
        applyStimulus();
        checkOutput("midRstWbReq", rfIf.wb_req_o, 0);
        checkOutput("midRstRfReq", rfIf.rf_req_o, 0);
        checkOutput("midRstAddr", rfIf.rf_addr_o, 0);
        checkOutput("midRstSecCnt", sec_cnt_o, 0);
        checkOutput("midRstErrAddr", err_addr_o, 0);
        rst_i = 1'b0;
        autoWbGnt = 1'b1;
        waitEvent("readWaitRestart", 3, reads + 1);
        checkOutput("restartAddr", lastReadAddr, 1);

        $display("[TB] DED counter saturation");
        mem[2] = orig[2] ^ (39'h3 << 2);
        mem[3] = orig[3] ^ (39'h3 << 3);
        mem[4] = orig[4] ^ (39'h3 << 4);
        mem[6] = orig[6] ^ (39'h3 << 6);
        mem[8] = orig[8] ^ (39'h3 << 8);
        target = dedSeen + 5;
        waitEvent("dedWaitSat", 1, target);
        checkOutput("satLastAddr", lastEvtAddr, 8);
        applyStimulus();
        checkOutput("dedCntSat", ded_cnt_o, 3);
        checkOutput("satErrAddr", err_addr_o, 8);
        checkOutput("satSecCnt", sec_cnt_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
